// File: rtl/lot_display_pkg.sv
// Shared glyph codes, FSM states and helpers for the parking-lot occupancy display.
package lot_display_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t G_0     = 5'd0;
  localparam glyph_t G_1     = 5'd1;
  localparam glyph_t G_2     = 5'd2;
  localparam glyph_t G_3     = 5'd3;
  localparam glyph_t G_4     = 5'd4;
  localparam glyph_t G_5     = 5'd5;
  localparam glyph_t G_6     = 5'd6;
  localparam glyph_t G_7     = 5'd7;
  localparam glyph_t G_8     = 5'd8;
  localparam glyph_t G_9     = 5'd9;
  localparam glyph_t G_A     = 5'd10;
  localparam glyph_t G_C     = 5'd12;
  localparam glyph_t G_E     = 5'd14;
  localparam glyph_t G_F     = 5'd15;
  localparam glyph_t G_L     = 5'd21;
  localparam glyph_t G_R     = 5'd27;
  localparam glyph_t G_U     = 5'd30;
  localparam glyph_t G_BLANK = 5'd31;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} disp_state_t;

  function automatic int num_digits(input int n);
    int d;
    int r;
    d = 1;
    r = n;
    while (r >= 10) begin
      r = r / 10;
      d = d + 1;
    end
    return d;
  endfunction

  // CLEAR0 spelled across digit positions 5..0
  function automatic glyph_t clear_glyph(input int pos);
    case (pos)
      5:       return G_C;
      4:       return G_L;
      3:       return G_E;
      2:       return G_A;
      1:       return G_R;
      default: return G_0;
    endcase
  endfunction

  // FULL spelled across offsets 3..0 above the number field
  function automatic glyph_t full_glyph(input int pos);
    case (pos)
      3:       return G_F;
      2:       return G_U;
      default: return G_L;
    endcase
  endfunction

endpackage

// File: rtl/lot_glyph_encoder.sv
// Glyph code to active-low seven-segment pattern (bit order g..a); unknown glyphs stay dark.
module lot_glyph_encoder
  import lot_display_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (glyph)
      G_0:     seg = 7'h40;
      G_1:     seg = 7'h79;
      G_2:     seg = 7'h24;
      G_3:     seg = 7'h30;
      G_4:     seg = 7'h19;
      G_5:     seg = 7'h12;
      G_6:     seg = 7'h02;
      G_7:     seg = 7'h78;
      G_8:     seg = 7'h00;
      G_9:     seg = 7'h10;
      G_A:     seg = 7'h08;
      G_C:     seg = 7'h46;
      G_E:     seg = 7'h06;
      G_F:     seg = 7'h0E;
      G_L:     seg = 7'h47;
      G_R:     seg = 7'h2F;
      G_U:     seg = 7'h41;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/lot_status_display.sv
// Occupancy display driver: sequential double-dabble conversion, CLEAR/FULL message
// composition with FULL blinking, and a registered seven-segment output bank.
module lot_status_display
  import lot_display_pkg::*;
#(
  parameter int CAPACITY  = 25,
  parameter int CNT_W     = $clog2(CAPACITY + 1),
  parameter int NUM_HEX   = 6,
  parameter int BLINK_DIV = 25_000_000,
  parameter int BLINK_EN  = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      RST,
  input  logic [CNT_W-1:0]          cntNum,
  output logic [NUM_HEX-1:0][6:0]   HEX,
  output logic                      busy
);

  localparam int ND         = num_digits(CAPACITY);
  localparam int BCD_W      = 4 * ND;
  localparam int SR_W       = BCD_W + CNT_W;
  localparam int IT_W       = $clog2(CNT_W + 1);
  localparam int BC_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam bit CLEAR_FITS = (NUM_HEX >= 6);
  localparam bit FULL_FITS  = (NUM_HEX >= ND + 4);
  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

  if (ND > NUM_HEX) begin : g_nd_check
    $error("lot_status_display: CAPACITY needs more digits than NUM_HEX provides");
  end

  disp_state_t          state_reg;
  logic [SR_W-1:0]      sr_reg;
  logic [SR_W-1:0]      sr_adj;
  logic [SR_W-1:0]      sr_next;
  logic [IT_W-1:0]      it_reg;
  logic [CNT_W-1:0]     v_reg;
  logic [CNT_W-1:0]     last_cnt_reg;
  logic [CNT_W-1:0]     v_clamp;
  logic                 dirty_reg;
  logic                 busy_reg;
  glyph_t               glyph_reg  [NUM_HEX];
  glyph_t               glyph_next [NUM_HEX];
  glyph_t               shown      [NUM_HEX];
  logic [NUM_HEX-1:0]   mask_reg;
  logic [NUM_HEX-1:0]   mask_next;
  logic                 full_reg;
  logic                 full_next;
  logic [BC_W-1:0]      blink_cnt_reg;
  logic                 phase_reg;
  logic [NUM_HEX-1:0][6:0] seg_w;
  logic [NUM_HEX-1:0][6:0] hex_reg;
  logic [3:0]           dig [NUM_HEX];
  int                   top_nz;

  assign v_clamp = (cntNum >= CAP_V) ? CAP_V : cntNum;

  // One shift-add-3 step: correct every BCD nibble first, then shift the whole register.
  always_comb begin
    sr_adj = sr_reg;
    for (int d = 0; d < ND; d++) begin
      if (sr_reg[CNT_W + 4*d +: 4] >= 4'd5)
        sr_adj[CNT_W + 4*d +: 4] = sr_reg[CNT_W + 4*d +: 4] + 4'd3;
    end
    sr_next = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    for (int i = 0; i < NUM_HEX; i++) dig[i] = 4'd0;
    for (int d = 0; d < ND; d++) dig[d] = sr_reg[CNT_W + 4*d +: 4];
    top_nz = 0;
    for (int i = 0; i < NUM_HEX; i++) begin
      if (dig[i] != 4'd0) top_nz = i;
    end
  end

  // Message composition; leading zeros suppressed so zero still shows a single '0'.
  always_comb begin
    full_next = 1'b0;
    mask_next = '0;
    for (int i = 0; i < NUM_HEX; i++) begin
      glyph_next[i] = G_BLANK;
      if (i <= top_nz) glyph_next[i] = glyph_t'({1'b0, dig[i]});
    end
    if (v_reg == '0 && CLEAR_FITS) begin
      for (int i = 0; i < NUM_HEX; i++) begin
        if (i < 6) glyph_next[i] = clear_glyph(i);
      end
    end else if (v_reg == CAP_V && FULL_FITS) begin
      full_next = 1'b1;
      for (int i = 0; i < NUM_HEX; i++) begin
        if (i >= ND && i < ND + 4) begin
          glyph_next[i] = full_glyph(i - ND);
          mask_next[i]  = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_enc
    assign shown[gi] = (phase_reg && mask_reg[gi]) ? G_BLANK : glyph_reg[gi];
    lot_glyph_encoder u_enc (
      .glyph (shown[gi]),
      .seg   (seg_w[gi])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      it_reg        <= '0;
      v_reg         <= '0;
      last_cnt_reg  <= '0;
      dirty_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      glyph_reg     <= '{default: G_BLANK};
      mask_reg      <= '0;
      full_reg      <= 1'b0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      hex_reg       <= {NUM_HEX{SEG_OFF}};
    end else begin
      case (state_reg)
        IDLE: begin
          if (dirty_reg || cntNum != last_cnt_reg) begin
            sr_reg       <= {{BCD_W{1'b0}}, v_clamp};
            v_reg        <= v_clamp;
            last_cnt_reg <= cntNum;
            dirty_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            it_reg       <= '0;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          sr_reg <= sr_next;
          it_reg <= it_reg + 1'b1;
          if (it_reg == IT_W'(CNT_W - 1)) state_reg <= LOAD;
        end
        LOAD: begin
          glyph_reg <= glyph_next;
          mask_reg  <= mask_next;
          full_reg  <= full_next;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Blink timer only runs while FULL is on screen, so FULL always appears lit first.
      if (!full_reg || BLINK_EN == 0) begin
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b0;
      end else if (blink_cnt_reg == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end

      hex_reg <= seg_w;
    end
  end

  assign HEX  = hex_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_lot_status_display.sv
// Directed bench for lot_status_display: CAPACITY=25 main instance plus a CAPACITY=120 instance.
module tb_lot_status_display;

  localparam logic [6:0] S_0 = 7'h40, S_1 = 7'h79, S_2 = 7'h24, S_3 = 7'h30, S_4 = 7'h19;
  localparam logic [6:0] S_5 = 7'h12, S_7 = 7'h78, S_9 = 7'h10;
  localparam logic [6:0] S_C = 7'h46, S_L = 7'h47, S_E = 7'h06, S_A = 7'h08, S_R = 7'h2F;
  localparam logic [6:0] S_F = 7'h0E, S_U = 7'h41, OFF = 7'h7F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [4:0]       cnt;
  logic [5:0][6:0]  hex;
  logic             busy;
  logic [6:0]       cnt2;
  logic [5:0][6:0]  hex2;
  logic             busy2;

  lot_status_display #(.CAPACITY(25), .NUM_HEX(6), .BLINK_DIV(4), .BLINK_EN(1)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .cntNum   (cnt),
    .HEX      (hex),
    .busy     (busy)
  );

  lot_status_display #(.CAPACITY(120), .NUM_HEX(6), .BLINK_DIV(4), .BLINK_EN(1)) dut120 (
    .CLOCK_50 (clk),
    .RST      (rst),
    .cntNum   (cnt2),
    .HEX      (hex2),
    .busy     (busy2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int bc;
    int vis;
    int seen9;
    logic v;

    rst  = 1'b1;
    cnt  = 5'd0;
    cnt2 = 7'd0;
    $display("txn: reset asserted, cntNum=0");
    tick(1);
    check("rst_hex_c1", 64'(hex), 64'({6{OFF}}));
    check("rst_busy_c1", 64'(busy), 64'(1'b0));
    tick(1);
    check("rst_hex_c2", 64'(hex), 64'({6{OFF}}));
    check("rst_hex120", 64'(hex2), 64'({6{OFF}}));

    rst = 1'b0;
    $display("txn: reset released");
    tick(7);
    check("clear_early", 64'(hex[0]), 64'(OFF));
    tick(1);
    check("clear0", 64'(hex), 64'({S_C, S_L, S_E, S_A, S_R, S_0}));

    cnt = 5'd17;
    $display("txn: cntNum=17");
    bc = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (busy) bc++;
      if (i == 7) check("n17_early", 64'(hex[0]), 64'(S_0));
    end
    check("n17_busy_cycles", 64'(bc), 64'(6));
    check("n17_hex", 64'(hex), 64'({OFF, OFF, OFF, OFF, S_1, S_7}));

    cnt = 5'd25;
    $display("txn: cntNum=25");
    tick(8);
    for (int k = 0; k < 12; k++) begin
      v = ((k / 4) % 2) == 0;
      check("full25_f", 64'(hex[5]), 64'(v ? S_F : OFF));
      check("full25_l", 64'(hex[2]), 64'(v ? S_L : OFF));
      check("full25_num", 64'(hex[1:0]), 64'({S_2, S_5}));
      tick(1);
    end

    cnt = 5'd31;
    $display("txn: cntNum=31");
    tick(8);
    vis = 0;
    for (int k = 0; k < 8; k++) begin
      check("full31_num", 64'(hex[1:0]), 64'({S_2, S_5}));
      if (hex[5:2] == {S_F, S_U, S_L, S_L}) vis++;
      tick(1);
    end
    check("full31_visible", 64'(vis), 64'(4));

    cnt = 5'd24;
    $display("txn: cntNum=24");
    tick(8);
    for (int k = 0; k < 8; k++) begin
      check("n24_hex", 64'(hex), 64'({OFF, OFF, OFF, OFF, S_2, S_4}));
      tick(1);
    end

    cnt = 5'd5;
    $display("txn: cntNum=5");
    tick(1);
    cnt = 5'd9;
    $display("txn: cntNum=9");
    tick(2);
    cnt = 5'd12;
    $display("txn: cntNum=12");
    seen9 = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (hex[0] == S_9) seen9++;
    end
    check("skip9_seen", 64'(seen9), 64'(0));
    check("n12_hex", 64'(hex), 64'({OFF, OFF, OFF, OFF, S_1, S_2}));

    cnt = 5'd13;
    $display("txn: cntNum=13 then reset mid-conversion");
    tick(3);
    check("n13_busy", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    tick(1);
    check("midrst_hex", 64'(hex), 64'({6{OFF}}));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    rst = 1'b0;
    tick(8);
    check("n13_hex", 64'(hex), 64'({OFF, OFF, OFF, OFF, S_1, S_3}));

    tick(4);
    check("cap120_clear", 64'(hex2), 64'({S_C, S_L, S_E, S_A, S_R, S_0}));
    cnt2 = 7'd120;
    $display("txn: cap120 cntNum=120");
    tick(10);
    for (int k = 0; k < 8; k++) begin
      check("cap120_full", 64'(hex2), 64'({OFF, OFF, OFF, S_1, S_2, S_0}));
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
